// File: rtl/regfile_port_arb_pkg.sv
// Shared widths, grant tags and payload structs for the Regfile port arbiter.
package regfile_port_arb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // Which requester owns the Regfile port in a given cycle.
    typedef enum logic [1:0] {
        RF_GNT_NONE = 2'd0,
        RF_GNT_WR   = 2'd1,
        RF_GNT_ID   = 2'd2,
        RF_GNT_DBG  = 2'd3
    } rf_gnt_e;

    // One buffered write-back.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Read context captured at grant time, consumed when the Regfile data returns.
    typedef struct packed {
        logic            fwd1;
        logic            fwd2;
        logic            zero1;
        logic            zero2;
        logic [XLEN-1:0] fwd_data;
    } rsp_ctx_t;

endpackage

// File: rtl/regfile_port_arb_wbuf.sv
// One-entry write buffer with address-compare outputs for read forwarding.
module regfile_port_arb_wbuf
    import regfile_port_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic [REG_ADDR_W-1:0] cmp_addr1,
    input  logic [REG_ADDR_W-1:0] cmp_addr2,
    output logic                  full,
    output wb_entry_t             entry,
    output logic                  hit1_c,
    output logic                  hit2_c
);

    // Refill wins over drain so a write can be retired and replaced in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (push) begin
            full  <= 1'b1;
            entry <= push_entry;
        end else if (pop) begin
            full  <= 1'b0;
        end
    end

    // A read hits only a live entry at a nonzero address.
    always_comb begin
        hit1_c = full && (cmp_addr1 == entry.addr) && (cmp_addr1 != '0);
        hit2_c = full && (cmp_addr2 == entry.addr) && (cmp_addr2 != '0);
    end

endmodule

// File: rtl/regfile_port_arb.sv
// Single owner of the Regfile port: arbitrates WB writes, ID reads and debug reads.
module regfile_port_arb
    import regfile_port_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  id_req,
    output logic                  id_gnt,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  id_rsp_valid,
    output logic [XLEN-1:0]       id_rdata1,
    output logic [XLEN-1:0]       id_rdata2,
    input  logic                  dbg_req,
    output logic                  dbg_gnt,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic                  dbg_rsp_valid,
    output logic [XLEN-1:0]       dbg_rdata,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [REG_ADDR_W-1:0] rf_raddr1,
    output logic [REG_ADDR_W-1:0] rf_raddr2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    rf_gnt_e          gnt_tag_c;
    logic             wr_gnt_c;
    logic             read_pend_c;
    logic             starve_hit_c;
    logic             push_c;
    logic [CNT_W-1:0] starve_cnt;

    logic             buf_full;
    wb_entry_t        buf_entry;
    wb_entry_t        push_entry_c;
    logic             hit1_c;
    logic             hit2_c;

    rsp_ctx_t         ctx_c;
    rsp_ctx_t         ctx_q;
    logic [XLEN-1:0]  rd1_c;
    logic [XLEN-1:0]  rd2_c;
    logic [XLEN-1:0]  id_rdata1_q;
    logic [XLEN-1:0]  id_rdata2_q;
    logic [XLEN-1:0]  dbg_rdata_q;

    assign read_pend_c  = id_req | dbg_req;
    assign starve_hit_c = (starve_cnt == CNT_W'(STARVE_MAX));

    // Port grant: buffered write first unless a read has waited STARVE_MAX write cycles.
    always_comb begin
        gnt_tag_c = RF_GNT_NONE;
        if (!rst_n) begin
            gnt_tag_c = RF_GNT_NONE;
        end else if (buf_full && !(read_pend_c && starve_hit_c)) begin
            gnt_tag_c = RF_GNT_WR;
        end else if (id_req) begin
            gnt_tag_c = RF_GNT_ID;
        end else if (dbg_req) begin
            gnt_tag_c = RF_GNT_DBG;
        end
    end

    assign wr_gnt_c = (gnt_tag_c == RF_GNT_WR);
    assign id_gnt   = (gnt_tag_c == RF_GNT_ID);
    assign dbg_gnt  = (gnt_tag_c == RF_GNT_DBG);

    // Accept while empty or while the current entry drains; x0 writes are swallowed.
    assign wb_ready = rst_n & (~buf_full | wr_gnt_c);
    assign push_c   = wb_valid & wb_ready & (wb_addr != '0);

    // Incoming write payload into the buffer.
    always_comb begin
        push_entry_c      = '0;
        push_entry_c.addr = wb_addr;
        push_entry_c.data = wb_data;
    end

    regfile_port_arb_wbuf u_wbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_c),
        .push_entry (push_entry_c),
        .pop        (wr_gnt_c),
        .cmp_addr1  (rf_raddr1),
        .cmp_addr2  (rf_raddr2),
        .full       (buf_full),
        .entry      (buf_entry),
        .hit1_c     (hit1_c),
        .hit2_c     (hit2_c)
    );

    // Regfile command for the winning requester; idle cycles issue a discarded read.
    always_comb begin
        rf_wr_en  = wr_gnt_c;
        rf_waddr  = buf_entry.addr;
        rf_wdata  = buf_entry.data;
        rf_raddr1 = id_rs1;
        rf_raddr2 = id_rs2;
        if (dbg_gnt) begin
            rf_raddr1 = dbg_addr;
            rf_raddr2 = '0;
        end
    end

    // Count write wins that blocked a pending read; any other cycle resets the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (wr_gnt_c && read_pend_c) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Forwarding and zero-address context sampled at grant, before any same-cycle refill.
    always_comb begin
        ctx_c          = '0;
        ctx_c.fwd1     = hit1_c;
        ctx_c.fwd2     = hit2_c;
        ctx_c.zero1    = (rf_raddr1 == '0);
        ctx_c.zero2    = (rf_raddr2 == '0);
        ctx_c.fwd_data = buf_entry.data;
    end

    // Response strobes and read context, one cycle behind the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_rsp_valid  <= 1'b0;
            dbg_rsp_valid <= 1'b0;
            ctx_q         <= '0;
        end else begin
            id_rsp_valid  <= id_gnt;
            dbg_rsp_valid <= dbg_gnt;
            if (id_gnt || dbg_gnt) begin
                ctx_q <= ctx_c;
            end
        end
    end

    // Select returned data: x0 reads zero, forwarded data overrides the Regfile.
    always_comb begin
        rd1_c = rf_rdata1;
        rd2_c = rf_rdata2;
        if (ctx_q.zero1) begin
            rd1_c = '0;
        end else if (ctx_q.fwd1) begin
            rd1_c = ctx_q.fwd_data;
        end
        if (ctx_q.zero2) begin
            rd2_c = '0;
        end else if (ctx_q.fwd2) begin
            rd2_c = ctx_q.fwd_data;
        end
        id_rdata1 = id_rsp_valid  ? rd1_c : id_rdata1_q;
        id_rdata2 = id_rsp_valid  ? rd2_c : id_rdata2_q;
        dbg_rdata = dbg_rsp_valid ? rd1_c : dbg_rdata_q;
    end

    // Hold the last delivered data while no response is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_rdata1_q <= '0;
            id_rdata2_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            id_rdata1_q <= id_rdata1;
            id_rdata2_q <= id_rdata2;
            dbg_rdata_q <= dbg_rdata;
        end
    end

endmodule

// File: tb/tb_regfile_port_arb.sv
// Scoreboard bench for regfile_port_arb with a behavioural Regfile model.
module tb_regfile_port_arb;
    import regfile_port_arb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_req;
    logic        id_gnt;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rsp_valid;
    logic [31:0] id_rdata1;
    logic [31:0] id_rdata2;
    logic        dbg_req;
    logic        dbg_gnt;
    logic [4:0]  dbg_addr;
    logic        dbg_rsp_valid;
    logic [31:0] dbg_rdata;
    logic        rf_wr_en;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1 = '0;
    logic [31:0] rf_rdata2 = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int acc     = 0;
    int wr_start = 0;
    int wr_count = 0;

    logic [31:0] id_q1 [$];
    logic [31:0] id_q2 [$];
    logic [31:0] dbg_q [$];

    regfile_port_arb #(.STARVE_MAX(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .id_req        (id_req),
        .id_gnt        (id_gnt),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rsp_valid  (id_rsp_valid),
        .id_rdata1     (id_rdata1),
        .id_rdata2     (id_rdata2),
        .dbg_req       (dbg_req),
        .dbg_gnt       (dbg_gnt),
        .dbg_addr      (dbg_addr),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rdata     (dbg_rdata),
        .rf_wr_en      (rf_wr_en),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_raddr1     (rf_raddr1),
        .rf_raddr2     (rf_raddr2),
        .rf_rdata1     (rf_rdata1),
        .rf_rdata2     (rf_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile model: unwritten xN holds 0x1000_000N, x0 returns junk so the DUT must zero it.
    logic [31:0] rf_mem [32];
    logic [31:0] rf_vld = '0;

    function automatic logic [31:0] rf_peek(input logic [4:0] a);
        if (a == 5'd0) return 32'hDEAD_BEEF;
        if (rf_vld[a]) return rf_mem[a];
        return 32'h1000_0000 | 32'(a);
    endfunction

    always @(posedge clk) begin
        if (rf_wr_en) begin
            if (rf_waddr != 5'd0) begin
                rf_mem[rf_waddr] <= rf_wdata;
                rf_vld[rf_waddr] <= 1'b1;
            end
            wr_count <= wr_count + 1;
        end else begin
            rf_rdata1 <= rf_peek(rf_raddr1);
            rf_rdata2 <= rf_peek(rf_raddr2);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: response latency and data against the expected-response queues.
    logic prev_id_gnt  = 1'b0;
    logic prev_dbg_gnt = 1'b0;
    always @(negedge clk) begin
        logic [31:0] e1;
        logic [31:0] e2;
        if (!rst_n) begin
            prev_id_gnt  <= 1'b0;
            prev_dbg_gnt <= 1'b0;
        end else begin
            if (prev_id_gnt || id_rsp_valid)
                check("id_rsp_latency", 32'(id_rsp_valid), 32'(prev_id_gnt));
            if (prev_dbg_gnt || dbg_rsp_valid)
                check("dbg_rsp_latency", 32'(dbg_rsp_valid), 32'(prev_dbg_gnt));
            if (id_rsp_valid) begin
                if (id_q1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL id_rsp_unexpected: got rdata1 0x%08h with no read outstanding", id_rdata1);
                end else begin
                    e1 = id_q1.pop_front();
                    e2 = id_q2.pop_front();
                    check("id_rdata1", id_rdata1, e1);
                    check("id_rdata2", id_rdata2, e2);
                end
            end
            if (dbg_rsp_valid) begin
                if (dbg_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dbg_rsp_unexpected: got rdata 0x%08h with no read outstanding", dbg_rdata);
                end else begin
                    e1 = dbg_q.pop_front();
                    check("dbg_rdata", dbg_rdata, e1);
                end
            end
            prev_id_gnt  <= id_gnt;
            prev_dbg_gnt <= dbg_gnt;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_id(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] e1, input logic [31:0] e2);
        bit got = 1'b0;
        id_q1.push_back(e1);
        id_q2.push_back(e2);
        id_rs1 = rs1;
        id_rs2 = rs2;
        id_req = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (id_gnt) got = 1'b1;
            else next_cycle();
        end
        check("id_gnt_wait", 32'(got), 32'd1);
        next_cycle();
        id_req = 1'b0;
    endtask

    task automatic do_dbg(input logic [4:0] a, input logic [31:0] e);
        bit got = 1'b0;
        dbg_q.push_back(e);
        dbg_addr = a;
        dbg_req  = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (dbg_gnt) got = 1'b1;
            else next_cycle();
        end
        check("dbg_gnt_wait", 32'(got), 32'd1);
        next_cycle();
        dbg_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;  wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
        id_req = 1'b1; id_rs1 = 5'd5;   id_rs2 = 5'd6;
        dbg_req = 1'b1; dbg_addr = 5'd3;

        // Reset: no grants, no port activity, responses cleared.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_id_gnt",    32'(id_gnt),        32'd0);
        check("rst_dbg_gnt",   32'(dbg_gnt),       32'd0);
        check("rst_rf_wr_en",  32'(rf_wr_en),      32'd0);
        check("rst_id_rsp",    32'(id_rsp_valid),  32'd0);
        check("rst_dbg_rsp",   32'(dbg_rsp_valid), 32'd0);
        check("rst_id_rdata1", id_rdata1,          32'd0);
        check("rst_dbg_rdata", dbg_rdata,          32'd0);
        wb_valid = 1'b0; id_req = 1'b0; dbg_req = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // 1: write x5 then read rs1=5, rs2=0.
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        @(negedge clk);
        check("t1_wb_ready", 32'(wb_ready), 32'd1);
        next_cycle();
        wb_valid = 1'b0;
        do_id(5'd5, 5'd0, 32'h1234, 32'd0);

        // 2: x0 write is accepted but never reaches the Regfile; x0 reads as zero.
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
        @(negedge clk);
        check("t2_wb_ready", 32'(wb_ready), 32'd1);
        check("t2_wr_en_acc", 32'(rf_wr_en), 32'd0);
        next_cycle();
        wb_valid = 1'b0;
        @(negedge clk);
        check("t2_wr_en_after", 32'(rf_wr_en), 32'd0);
        next_cycle();
        do_dbg(5'd0, 32'd0);

        // 3: continuous x7 writes starve a held ID read until the 5th cycle; forwarded value.
        acc = 0;
        id_rs1 = 5'd7; id_rs2 = 5'd0;
        for (int k = 0; k < 7; k++) begin
            wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h7000_0001 + 32'(acc);
            if (k == 1) begin
                id_q1.push_back(32'h7000_0005);
                id_q2.push_back(32'd0);
                id_req = 1'b1;
            end
            @(negedge clk);
            check("t3_id_gnt",   32'(id_gnt),   32'(k == 5));
            check("t3_wb_ready", 32'(wb_ready), 32'(k != 5));
            if (wb_ready) acc++;
            next_cycle();
            if (k == 5) id_req = 1'b0;
        end
        wb_valid = 1'b0;
        do_dbg(5'd7, 32'h7000_0006);

        // 4: simultaneous ID and debug requests: ID first, debug next cycle.
        id_q1.push_back(32'h1000_0001);
        id_q2.push_back(32'h1000_0002);
        dbg_q.push_back(32'h1000_0003);
        id_rs1 = 5'd1; id_rs2 = 5'd2; dbg_addr = 5'd3;
        id_req = 1'b1; dbg_req = 1'b1;
        @(negedge clk);
        check("t4_id_gnt_n",  32'(id_gnt),  32'd1);
        check("t4_dbg_gnt_n", 32'(dbg_gnt), 32'd0);
        next_cycle();
        id_req = 1'b0;
        @(negedge clk);
        check("t4_dbg_gnt_n1", 32'(dbg_gnt),      32'd1);
        check("t4_id_rsp_n1",  32'(id_rsp_valid), 32'd1);
        next_cycle();
        dbg_req = 1'b0;

        // 5: reset mid-cycle with x3 buffered and a debug response in flight.
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
        dbg_addr = 5'd4; dbg_req = 1'b1;
        @(negedge clk);
        check("t5_dbg_gnt",  32'(dbg_gnt),  32'd1);
        check("t5_wb_ready", 32'(wb_ready), 32'd1);
        next_cycle();
        wb_valid = 1'b0; dbg_req = 1'b0;
        #1;
        check("t5_pre_wr_en",  32'(rf_wr_en),      32'd1);
        check("t5_pre_rsp",    32'(dbg_rsp_valid), 32'd1);
        check("t5_pre_rdata",  dbg_rdata,          32'h1000_0004);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_wr_en",  32'(rf_wr_en),      32'd0);
        check("t5_rst_rsp",    32'(dbg_rsp_valid), 32'd0);
        check("t5_rst_rdata",  dbg_rdata,          32'd0);
        repeat (2) next_cycle();
        rst_n = 1'b1;
        next_cycle();
        do_dbg(5'd3, 32'h1000_0003);

        // 6: write every cycle with no reads: always ready, one Regfile write per cycle.
        wr_start = wr_count;
        for (int k = 0; k < 8; k++) begin
            wb_valid = 1'b1; wb_addr = 5'(8 + k); wb_data = 32'h6000_0000 + 32'(k);
            @(negedge clk);
            check("t6_wb_ready", 32'(wb_ready), 32'd1);
            check("t6_wr_en",    32'(rf_wr_en), 32'(k != 0));
            next_cycle();
        end
        wb_valid = 1'b0;
        @(negedge clk);
        check("t6_wr_en_last", 32'(rf_wr_en), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t6_wr_count", 32'(wr_count - wr_start), 32'd8);
        next_cycle();
        do_dbg(5'd8,  32'h6000_0000);
        do_dbg(5'd15, 32'h6000_0007);

        repeat (4) next_cycle();
        check("sb_drained", 32'(id_q1.size() + dbg_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
